// File: rtl/clkdiv_ctrl_if.sv
// Control interface for clkdiv_ctrl: run request plus the half-period
// configuration valid/ready handshake.
interface clkdiv_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    logic             en;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] div_val;

    // Power-management / config side
    modport master (
        output en,
        output cfg_valid,
        output div_val,
        input  cfg_ready
    );

    // Divider side
    modport slave (
        input  en,
        input  cfg_valid,
        input  div_val,
        output cfg_ready
    );
endinterface

// File: rtl/clkdiv_ctrl.sv
// Glitch-free programmable clock divider controller.
// out_clk toggles every cur_div in_clk cycles. Gating (en) and ratio changes
// only take effect at the end of a low phase, so the consumers never see a
// runt pulse. Defining CLKDIV_CTRL_CNT_EN adds a 16-bit out_clk rise counter
// on the out_cycles port.
module clkdiv_ctrl #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DEFAULT_DIV = 1
) (
    input  logic         in_clk,
    input  logic         reset,
    clkdiv_ctrl_if.slave ctrl,
    output logic         out_clk,
    output logic         active
`ifdef CLKDIV_CTRL_CNT_EN
    ,
    output logic [15:0]  out_cycles
`endif
);

    // A zero default would stall the counter, so it is treated as 1 like div_val.
    localparam logic [CNT_W-1:0] DefDiv = (DEFAULT_DIV == 0) ? CNT_W'(1) : CNT_W'(DEFAULT_DIV);

    typedef enum logic [1:0] {
        StOff,
        StRun,
        StStopPend
    } state_e;

    state_e           state_q, state_d;
    logic             out_clk_q, out_clk_d;
    logic             active_q, active_d;
    logic [CNT_W-1:0] half_cnt_q, half_cnt_d;
    logic [CNT_W-1:0] cur_div_q, cur_div_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             pend_vld_q, pend_vld_d;

    logic             cfg_xfer;
    logic             half_last;
    logic [CNT_W-1:0] div_req;

    assign cfg_xfer  = ctrl.cfg_valid && !pend_vld_q;
    // cur_div is never zero, so cur_div-1 cannot wrap.
    assign half_last = (half_cnt_q == (cur_div_q - CNT_W'(1)));
    assign div_req   = (ctrl.div_val == '0) ? CNT_W'(1) : ctrl.div_val;

    // Next-state: phase counting, period-boundary gating and config staging
    always_comb begin
        state_d    = state_q;
        out_clk_d  = out_clk_q;
        half_cnt_d = half_cnt_q;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        pend_vld_d = pend_vld_q;

        case (state_q)
            StOff: begin
                half_cnt_d = '0;
                out_clk_d  = 1'b0;
                if (ctrl.en) begin
                    // First period runs on the old ratio; a pending value waits
                    // for the first boundary.
                    state_d   = StRun;
                    out_clk_d = 1'b1;
                end else if (pend_vld_q) begin
                    cur_div_d  = pend_div_q;
                    pend_vld_d = 1'b0;
                end
            end
            StRun, StStopPend: begin
                state_d = ctrl.en ? StRun : StStopPend;
                if (half_last) begin
                    half_cnt_d = '0;
                    if (out_clk_q) begin
                        out_clk_d = 1'b0;
                    end else begin
                        // End of low phase: the only point where ratio or gating changes.
                        if (pend_vld_q) begin
                            cur_div_d  = pend_div_q;
                            pend_vld_d = 1'b0;
                        end
                        if (state_q == StStopPend) begin
                            state_d   = StOff;
                            out_clk_d = 1'b0;
                        end else begin
                            out_clk_d = 1'b1;
                        end
                    end
                end else begin
                    half_cnt_d = half_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = StOff;
                out_clk_d  = 1'b0;
                half_cnt_d = '0;
            end
        endcase

        // pend_vld was clear, so this never collides with a boundary apply above.
        if (cfg_xfer) begin
            pend_div_d = div_req;
            pend_vld_d = 1'b1;
        end
    end

    assign active_d = (state_d != StOff);

    // State and datapath registers with synchronous reset
    always_ff @(posedge in_clk) begin
        if (reset) begin
            state_q    <= StOff;
            out_clk_q  <= 1'b0;
            active_q   <= 1'b0;
            half_cnt_q <= '0;
            cur_div_q  <= DefDiv;
            pend_div_q <= DefDiv;
            pend_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_clk_q  <= out_clk_d;
            active_q   <= active_d;
            half_cnt_q <= half_cnt_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    assign out_clk        = out_clk_q;
    assign active         = active_q;
    assign ctrl.cfg_ready = !pend_vld_q;

`ifdef CLKDIV_CTRL_CNT_EN
    logic [15:0] out_cycles_q;

    // Count out_clk rising edges, wrapping at 16 bits
    always_ff @(posedge in_clk) begin
        if (reset) begin
            out_cycles_q <= '0;
        end else if (!out_clk_q && out_clk_d) begin
            out_cycles_q <= out_cycles_q + 16'd1;
        end
    end

    assign out_cycles = out_cycles_q;
`else
    // No rise counter in this build.
`endif

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Self-checking bench for clkdiv_ctrl: a vector table, hand-written corner
// sequences and a randomized run against a period-position reference model.
module tb_clkdiv_ctrl;

    localparam int unsigned CNT_W       = 8;
    localparam int unsigned DEFAULT_DIV = 1;
    localparam int          NVEC        = 15;

    logic in_clk = 1'b0;
    logic reset;
    logic out_clk;
    logic active;
`ifdef CLKDIV_CTRL_CNT_EN
    logic [15:0] out_cycles;
`endif

    clkdiv_ctrl_if #(.CNT_W(CNT_W)) ctrl ();

    clkdiv_ctrl #(
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .in_clk    (in_clk),
        .reset     (reset),
        .ctrl      (ctrl),
        .out_clk   (out_clk),
        .active    (active)
`ifdef CLKDIV_CTRL_CNT_EN
        ,
        .out_cycles(out_cycles)
`endif
    );

    always #5 in_clk = ~in_clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: position inside the current output period.
    bit          m_on;
    bit          m_stop;
    bit          m_pv;
    int          m_pos;
    int          m_div;
    int          m_pdiv;
    logic [15:0] m_cyc;

    typedef struct {
        bit rst;
        bit en;
        bit cv;
        int dv;
        bit o;
        bit a;
        bit r;
    } vec_t;

    vec_t        tbl[NVEC];
    logic [31:0] ow;
    logic [31:0] aw;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit cv, input int dv);
        bit xfer;
        if (r) begin
            m_on = 0; m_stop = 0; m_pv = 0; m_pos = 0;
            m_div = DEFAULT_DIV; m_pdiv = DEFAULT_DIV; m_cyc = '0;
            return;
        end
        xfer = cv && !m_pv;
        if (!m_on) begin
            if (e) begin
                m_on = 1; m_stop = 0; m_pos = 0; m_cyc = m_cyc + 16'd1;
            end else if (m_pv) begin
                m_div = m_pdiv; m_pv = 0;
            end
        end else begin
            if (m_pos == 2 * m_div - 1) begin
                if (m_pv) begin
                    m_div = m_pdiv; m_pv = 0;
                end
                if (m_stop) begin
                    m_on = 0;
                end else begin
                    m_pos = 0; m_cyc = m_cyc + 16'd1;
                end
            end else begin
                m_pos++;
            end
            m_stop = !e;
        end
        if (xfer) begin
            m_pdiv = (dv == 0) ? 1 : dv;
            m_pv   = 1;
        end
    endtask

    task automatic tick(input bit r, input bit e, input bit cv, input int dv);
        reset          = r;
        ctrl.en        = e;
        ctrl.cfg_valid = cv;
        ctrl.div_val   = dv[CNT_W-1:0];
        model_step(r, e, cv, dv);
        @(posedge in_clk);
        #1;
    endtask

    // Run n cycles with fixed en, shifting out_clk/active into the words (first tick = MSB).
    task automatic capture(input int n, input bit e, output logic [31:0] o_w,
                           output logic [31:0] a_w);
        o_w = '0;
        a_w = '0;
        for (int i = 0; i < n; i++) begin
            tick(0, e, 0, 0);
            o_w = {o_w[30:0], out_clk};
            a_w = {a_w[30:0], active};
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit e;
        bit cv;
        bit r;
        int dv;

        reset          = 1'b1;
        ctrl.en        = 1'b0;
        ctrl.cfg_valid = 1'b0;
        ctrl.div_val   = '0;

        // rst, en, cv, dv -> out_clk, active, cfg_ready after the edge
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 1};
        tbl[1]  = '{0, 1, 0, 0, 1, 1, 1};
        tbl[2]  = '{0, 1, 0, 0, 0, 1, 1};
        tbl[3]  = '{0, 1, 0, 0, 1, 1, 1};
        tbl[4]  = '{0, 0, 0, 0, 0, 1, 1};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 1};
        tbl[6]  = '{0, 0, 1, 3, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 1};
        tbl[8]  = '{0, 1, 0, 0, 1, 1, 1};
        tbl[9]  = '{0, 1, 0, 0, 1, 1, 1};
        tbl[10] = '{0, 1, 0, 0, 1, 1, 1};
        tbl[11] = '{0, 1, 0, 0, 0, 1, 1};
        tbl[12] = '{0, 1, 0, 0, 0, 1, 1};
        tbl[13] = '{0, 1, 0, 0, 0, 1, 1};
        tbl[14] = '{0, 1, 0, 0, 1, 1, 1};

        for (int i = 0; i < NVEC; i++) begin
            tick(tbl[i].rst, tbl[i].en, tbl[i].cv, tbl[i].dv);
            check($sformatf("vec%0d_out_clk", i), out_clk, tbl[i].o);
            check($sformatf("vec%0d_active", i), active, tbl[i].a);
            check($sformatf("vec%0d_cfg_ready", i), ctrl.cfg_ready, tbl[i].r);
        end

        // Ratio change 2 -> 5 offered mid high phase: 2+2 completes, then 5+5.
        tick(1, 0, 0, 0); tick(0, 0, 1, 2); tick(0, 0, 0, 0); tick(0, 1, 0, 0);
        check("chg_first_high", out_clk, 1);
        tick(0, 1, 1, 5);
        check("chg_ready_low", ctrl.cfg_ready, 0);
        capture(13, 1, ow, aw);
        check("chg_wave", ow, 32'b0011111000001);
        check("chg_ready_back", ctrl.cfg_ready, 1);

        // Stop at div 4, en dropped one cycle into the high phase.
        tick(1, 0, 0, 0); tick(0, 0, 1, 4); tick(0, 0, 0, 0); tick(0, 1, 0, 0); tick(0, 0, 0, 0);
        check("stop_still_high", out_clk, 1);
        check("stop_still_active", active, 1);
        capture(7, 0, ow, aw);
        check("stop_wave", ow, 32'b1100000);
        check("stop_active", aw, 32'b1111110);

        // Drop and re-raise en before the boundary, then div_val=0 -> 1+1.
        tick(1, 0, 0, 0); tick(0, 0, 1, 4); tick(0, 0, 0, 0); tick(0, 1, 0, 0);
        tick(0, 0, 0, 0); tick(0, 1, 0, 0);
        capture(8, 1, ow, aw);
        check("rerun_wave", ow, 32'b10000111);
        check("rerun_active", aw, 32'hFF);
        tick(0, 1, 1, 0);
        capture(10, 1, ow, aw);
        check("div0_wave", ow, 32'b0000101010);

        // Reset while high at div 6 with a config pending.
        tick(1, 0, 0, 0); tick(0, 0, 1, 6); tick(0, 0, 0, 0); tick(0, 1, 0, 0);
        tick(0, 1, 1, 3);
        check("rst_pre_high", out_clk, 1);
        tick(1, 1, 0, 0);
        check("rst_out_clk", out_clk, 0);
        check("rst_active", active, 0);
        check("rst_cfg_ready", ctrl.cfg_ready, 1);
`ifdef CLKDIV_CTRL_CNT_EN
        check("rst_out_cycles", out_cycles, 0);
`endif
        capture(6, 1, ow, aw);
        check("rst_div1_wave", ow, 32'b101010);
`ifdef CLKDIV_CTRL_CNT_EN
        check("rst_out_cycles_3", out_cycles, 3);
`endif

        // Randomized run against the reference model.
        tick(1, 0, 0, 0);
        e = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 11) == 0) e = !e;
            cv = ($urandom_range(0, 5) == 0);
            dv = int'($urandom_range(0, 6));
            r  = ($urandom_range(0, 399) == 0);
            tick(r, e, cv, dv);
            check($sformatf("rnd%0d_out_clk", c), out_clk, (m_on && (m_pos < m_div)));
            check($sformatf("rnd%0d_active", c), active, m_on);
            check($sformatf("rnd%0d_cfg_ready", c), ctrl.cfg_ready, !m_pv);
`ifdef CLKDIV_CTRL_CNT_EN
            check($sformatf("rnd%0d_out_cycles", c), out_cycles, m_cyc);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
